mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and access sequencer for the single unified memory of the multicycle MIPS core. It shares the memory between two requesters:
- the CPU port, driven from the control unit's MemRd/MemWr and the IorD-selected address;
- the loader port, used for program load and debug.

It enforces a fixed-latency memory access. It stalls the CPU state register until the CPU's access completes.

## Interface
- AW, 32, address width
- DW, 32, data width
- LAT, 2, memory access cycles per transfer (legal range 1..15)

- CLK  in  1  system clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU access request (MemRd|MemWr)
- cpu_we  in  1  CPU write (MemWr)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, registered
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  freezes the state register: cpu_req & ~cpu_ack
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/AW/DW  loader request fields
- ld_rdata  out  DW  loader read data, registered
- ld_ack  out  1  loader completion pulse
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid in the last ACC cycle
- owner  out  1  current grant: 0 = CPU, 1 = loader
- busy  out  1  state ≠ IDLE

## Operation
- **FSM states:**
  - IDLE: no grant; mem_en = 0.
  - ACC: mem_en = 1 for exactly LAT cycles; down-counter cnt loads LAT-1 on entry.
  - RESP: one cycle; ack to the owner.
- **IDLE:**
  - one req high → grant it, go to ACC;
  - both high → round-robin: grant the port not in `last`;
  - none → stay.
- **Request capture:** the granted port's we/addr/wdata are latched into internal registers on entry to ACC. mem_we, mem_addr and mem_wdata drive from these registers, stable for the whole ACC phase.
- **Requester rule:** a requester holds req and its fields stable until its ack.
- **ACC:** cnt decrements each cycle. At cnt==0, go to RESP. On a read, capture mem_rdata into the owner's rdata register on that edge.
- **RESP:**
  - the owner's ack = 1; `last` ← owner;
  - the owner's req in this cycle is ignored as stale;
  - if the other port's req is high → grant it, go directly to ACC; else → IDLE.
- **Writes:** ack as for reads; the rdata register is unchanged.
- Only the owner's rdata register is ever updated.
- **mem_en:** 0 and mem_we 0 in IDLE and RESP; mem_we is only ever high while mem_en is high.
- **cpu_stall:** combinational.
  - High from the cycle cpu_req rises through the cycle before cpu_ack.
  - Low in the ack cycle, so the state register advances on that edge.
- **Reset (any time, including mid-ACC):**
  - state = IDLE, cnt = 0, `last` = loader (the CPU wins the first tie), owner = 0;
  - all acks, mem_en and mem_we = 0; both rdata registers = 0; busy = 0;
  - an interrupted access is dropped and no ack is issued.

## Timing
- **Latency:** req high in cycle 0 with FSM in IDLE → ACC in cycles 1..LAT → ack and rdata valid in cycle LAT+1.
- **Throughput:**
  - same port back-to-back: LAT+2 cycles per access (IDLE visited);
  - alternating ports under contention: LAT+1 cycles per access (RESP→ACC).
- **Arbitration:** a request raised while the other port is in ACC waits. It is granted in that port's RESP cycle, with no IDLE gap.
- **Starvation:** none; under continuous contention, grants strictly alternate.
- **LAT=1:** ACC lasts one cycle; cnt loads 0.

## Structure
- **Shared package `mc_pkg`:**
  - state encoding: IDLE = 2'd0, ACC = 2'd1, RESP = 2'd2;
  - owner encoding: OWN_CPU = 0, OWN_LD = 1;
  - default LAT.
- **Sub-module `rr_arb2`:** combinational two-requester round-robin.
  - Inputs: req[1:0], last, mask[1:0]; mask excludes the stale RESP owner.
  - Outputs: gnt_valid, gnt_id.
- Counter, capture registers and FSM live in mem_arbiter.

## Test plan
- **Reset then CPU read:** RST_N low→high; LAT=2; cpu_req=1, cpu_addr=0x10, mem returns 0x8C010004.
  - mem_en high in cycles 1–2, cpu_ack in cycle 3, cpu_rdata=0x8C010004;
  - cpu_stall high in cycles 0–2 and low in cycle 3.
- **Loader write:** ld_we=1, ld_addr=0x20, ld_wdata=0xDEADBEEF.
  - mem_we=1 with mem_addr=0x20 for 2 cycles; ld_ack pulse; ld_rdata unchanged (0).
- **Simultaneous requests after reset:** CPU granted first (owner=0).
  - Loader enters ACC directly from the CPU's RESP.
  - Acks at cycles 3 and 6.
- **Continuous contention over 6 accesses:** owner sequence 0,1,0,1,0,1; no IDLE cycles between accesses.
- **Reset mid-ACC:** RST_N low during ACC cycle 1.
  - Outputs zero immediately (async); no ack ever issued for that access.
  - After release, a fresh cpu_req completes normally.
- **LAT=1 build:** CPU read → ack in cycle 2; back-to-back same-port accesses every 3 cycles.

Source files
------------

// File: rtl/mc_pkg.sv
//==============================================================================
// Module      : mc_pkg
// Description : Shared encodings for the unified-memory arbiter.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package mc_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LD  = 1'b1;

    localparam int LAT_DEFAULT = 2;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
//==============================================================================
// Module      : mem_arbiter_if
// Description : CPU, loader and memory-side signals of the memory arbiter.
// Revision    : 1.0
//==============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;

    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic [DW-1:0] ld_rdata;
    logic          ld_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          owner;
    logic          busy;

    // Arbiter side
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_rdata, ld_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner, busy
    );

    // Requester and memory side
    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_rdata, ld_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner, busy
    );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
//==============================================================================
// Module      : rr_arb2
// Description : Combinational two-requester round-robin (bit 0 CPU, bit 1 loader).
// Revision    : 1.0
//==============================================================================
`default_nettype none

module rr_arb2
    import mc_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] mask,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic [1:0] w_elig;

    assign w_elig = req & ~mask;

    always_comb begin
        gnt_valid = |w_elig;
        gnt_id    = OWN_CPU;
        case (w_elig)
            2'b01:   gnt_id = OWN_CPU;
            2'b10:   gnt_id = OWN_LD;
            2'b11:   gnt_id = ~last;
            default: gnt_id = OWN_CPU;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//==============================================================================
// Module      : mem_arbiter
// Description : Fixed-latency CPU/loader arbiter and sequencer for unified memory.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module mem_arbiter
    import mc_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = LAT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_last;
    logic          r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_ld_rdata;

    logic [1:0]    w_req;
    logic [1:0]    w_mask;
    logic          w_gnt_valid;
    logic          w_gnt_id;
    logic          w_start;
    logic          w_resp;

    assign w_req  = {bus.ld_req, bus.cpu_req};
    assign w_resp = (r_state == RESP);
    // The RESP owner's request is stale and must not win a second grant
    assign w_mask = w_resp ? ((r_owner == OWN_LD) ? 2'b10 : 2'b01) : 2'b00;

    rr_arb2 u_rr_arb2 (
        .req       (w_req),
        .last      (r_last),
        .mask      (w_mask),
        .gnt_valid (w_gnt_valid),
        .gnt_id    (w_gnt_id)
    );

    assign w_start = w_gnt_valid && ((r_state == IDLE) || w_resp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_last      <= OWN_LD;
            r_owner     <= OWN_CPU;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_ld_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) r_state <= ACC;
                end
                ACC: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                        if (!r_we) begin
                            if (r_owner == OWN_LD) r_ld_rdata  <= bus.mem_rdata;
                            else                   r_cpu_rdata <= bus.mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_last  <= r_owner;
                    r_state <= w_start ? ACC : IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (w_start) begin
                r_owner <= w_gnt_id;
                r_cnt   <= 4'(LAT - 1);
                r_we    <= (w_gnt_id == OWN_LD) ? bus.ld_we    : bus.cpu_we;
                r_addr  <= (w_gnt_id == OWN_LD) ? bus.ld_addr  : bus.cpu_addr;
                r_wdata <= (w_gnt_id == OWN_LD) ? bus.ld_wdata : bus.cpu_wdata;
            end
        end
    end

    assign bus.mem_en    = (r_state == ACC);
    assign bus.mem_we    = bus.mem_en & r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    assign bus.cpu_ack   = w_resp && (r_owner == OWN_CPU);
    assign bus.ld_ack    = w_resp && (r_owner == OWN_LD);
    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.ld_rdata  = r_ld_rdata;
    assign bus.owner     = r_owner;
    assign bus.busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench: directed scenarios plus randomized traffic.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int LATV = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) ifc ();
    mem_arbiter_if #(.AW(32), .DW(32)) ifc1 ();

    mem_arbiter #(.AW(32), .DW(32), .LAT(LATV)) dut  (.clk(clk), .rst_n(rst_n), .bus(ifc));
    mem_arbiter #(.AW(32), .DW(32), .LAT(1))    dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

    logic [31:0] mem       [0:255];
    logic [31:0] model_mem [0:255];

    function automatic logic [31:0] init_word(int i);
        if (i == 16) return 32'h8C01_0004;
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    assign ifc.mem_rdata  = ifc.mem_en ? mem[ifc.mem_addr[7:0]] : 32'h0;
    assign ifc1.mem_rdata = ifc1.mem_addr ^ 32'h5A5A_0000;

    always @(posedge clk) begin
        if (ifc.mem_en && ifc.mem_we) mem[ifc.mem_addr[7:0]] = ifc.mem_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.cpu_req = 0; ifc.cpu_we = 0; ifc.cpu_addr = 0; ifc.cpu_wdata = 0;
        ifc.ld_req  = 0; ifc.ld_we  = 0; ifc.ld_addr  = 0; ifc.ld_wdata  = 0;
        ifc1.cpu_req = 0; ifc1.cpu_we = 0; ifc1.cpu_addr = 0; ifc1.cpu_wdata = 0;
        ifc1.ld_req  = 0; ifc1.ld_we  = 0; ifc1.ld_addr  = 0; ifc1.ld_wdata  = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [5:0] got;
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        got = {ifc.busy, ifc.mem_en, ifc.mem_we, ifc.cpu_ack, ifc.ld_ack, ifc.owner};
        checks++;
        if (got !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000", got);
        end
        checks++;
        if (ifc.cpu_rdata !== 32'h0 || ifc.ld_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h/%h exp 0/0", ifc.cpu_rdata, ifc.ld_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b exp 0", ifc.busy);
        end
    endtask

    task automatic test_cpu_read();
        ifc.cpu_req = 1; ifc.cpu_we = 0; ifc.cpu_addr = 32'h10;
        #1;
        checks++;
        if (ifc.cpu_stall !== 1'b1 || ifc.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_c0 stall/en got %b%b exp 10", ifc.cpu_stall, ifc.mem_en);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if ({ifc.mem_en, ifc.cpu_ack, ifc.cpu_stall} !== {k <= 2, k == 3, k != 3}) begin
                errors++;
                $display("FAIL cpu_read_c%0d en/ack/stall got %b%b%b exp %b%b%b", k,
                         ifc.mem_en, ifc.cpu_ack, ifc.cpu_stall, k <= 2, k == 3, k != 3);
            end
        end
        checks++;
        if (ifc.cpu_rdata !== 32'h8C01_0004) begin
            errors++;
            $display("FAIL cpu_read_data got %h exp 8c010004", ifc.cpu_rdata);
        end
        ifc.cpu_req = 0;
        step();
        checks++;
        if (ifc.busy !== 1'b0 || ifc.cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_after busy/ack got %b%b exp 00", ifc.busy, ifc.cpu_ack);
        end
    endtask

    task automatic test_ld_write();
        ifc.ld_req = 1; ifc.ld_we = 1; ifc.ld_addr = 32'h20; ifc.ld_wdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k <= 2) begin
                checks++;
                if (ifc.mem_we !== 1'b1 || ifc.mem_addr !== 32'h20 || ifc.mem_wdata !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL ld_write_c%0d we/addr/wdata got %b/%h/%h exp 1/20/deadbeef",
                             k, ifc.mem_we, ifc.mem_addr, ifc.mem_wdata);
                end
            end else begin
                checks++;
                if (ifc.ld_ack !== 1'b1 || ifc.mem_we !== 1'b0 || ifc.ld_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL ld_write_ack ack/we/rdata got %b/%b/%h exp 1/0/0",
                             ifc.ld_ack, ifc.mem_we, ifc.ld_rdata);
                end
            end
        end
        ifc.ld_req = 0; ifc.ld_we = 0;
        step();
        checks++;
        if (mem[8'h20] !== 32'hDEAD_BEEF || ifc.ld_ack !== 1'b0) begin
            errors++;
            $display("FAIL ld_write_mem got %h ack %b exp deadbeef 0", mem[8'h20], ifc.ld_ack);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        ifc.cpu_req = 1; ifc.cpu_addr = 32'h10;
        ifc.ld_req  = 1; ifc.ld_addr  = 32'h30;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if ({ifc.owner, ifc.mem_en, ifc.cpu_ack, ifc.ld_ack} !==
                {k >= 4, (k % 3) != 0, k == 3, k == 6}) begin
                errors++;
                $display("FAIL simul_c%0d own/en/cack/lack got %b%b%b%b exp %b%b%b%b", k,
                         ifc.owner, ifc.mem_en, ifc.cpu_ack, ifc.ld_ack,
                         k >= 4, (k % 3) != 0, k == 3, k == 6);
            end
            if (k == 3) ifc.cpu_req = 0;
            if (k == 6) ifc.ld_req = 0;
        end
        checks++;
        if (ifc.cpu_rdata !== 32'h8C01_0004 || ifc.ld_rdata !== init_word(8'h30)) begin
            errors++;
            $display("FAIL simul_data got %h/%h exp 8c010004/%h", ifc.cpu_rdata, ifc.ld_rdata,
                     init_word(8'h30));
        end
    endtask

    task automatic test_contention();
        logic exp_own;
        do_reset();
        ifc.cpu_req = 1; ifc.cpu_addr = 32'h10;
        ifc.ld_req  = 1; ifc.ld_addr  = 32'h30;
        for (int k = 1; k <= 18; k++) begin
            step();
            exp_own = ((k - 1) / 3) % 2 == 1;
            checks++;
            if ({ifc.busy, ifc.owner, ifc.mem_en, ifc.cpu_ack, ifc.ld_ack} !==
                {1'b1, exp_own, (k % 3) != 0, (k % 3 == 0) && !exp_own, (k % 3 == 0) && exp_own}) begin
                errors++;
                $display("FAIL contend_c%0d busy/own/en/cack/lack got %b%b%b%b%b exp 1%b%b%b%b", k,
                         ifc.busy, ifc.owner, ifc.mem_en, ifc.cpu_ack, ifc.ld_ack, exp_own,
                         (k % 3) != 0, (k % 3 == 0) && !exp_own, (k % 3 == 0) && exp_own);
            end
        end
        ifc.cpu_req = 0; ifc.ld_req = 0;
        step();
    endtask

    task automatic test_reset_mid_acc();
        do_reset();
        ifc.cpu_req = 1; ifc.cpu_we = 0; ifc.cpu_addr = 32'h10;
        step();
        checks++;
        if (ifc.mem_en !== 1'b1) begin
            errors++;
            $display("FAIL midrst_acc mem_en got %b exp 1", ifc.mem_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ifc.mem_en, ifc.mem_we, ifc.busy, ifc.cpu_ack, ifc.ld_ack, ifc.owner} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_async en/we/busy/cack/lack/own got %b%b%b%b%b%b exp 000000",
                     ifc.mem_en, ifc.mem_we, ifc.busy, ifc.cpu_ack, ifc.ld_ack, ifc.owner);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (ifc.cpu_ack !== 1'b0 || ifc.busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_hold_c%0d ack/busy got %b%b exp 00", k, ifc.cpu_ack, ifc.busy);
            end
        end
        ifc.cpu_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (ifc.cpu_ack !== 1'b0 || ifc.busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_noack_c%0d ack/busy got %b%b exp 00", k, ifc.cpu_ack, ifc.busy);
            end
        end
        ifc.cpu_req = 1; ifc.cpu_addr = 32'h44;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if ({ifc.mem_en, ifc.cpu_ack} !== {k <= 2, k == 3}) begin
                errors++;
                $display("FAIL midrst_fresh_c%0d en/ack got %b%b exp %b%b", k,
                         ifc.mem_en, ifc.cpu_ack, k <= 2, k == 3);
            end
        end
        checks++;
        if (ifc.cpu_rdata !== init_word(8'h44)) begin
            errors++;
            $display("FAIL midrst_fresh_data got %h exp %h", ifc.cpu_rdata, init_word(8'h44));
        end
        ifc.cpu_req = 0;
        step();
    endtask

    task automatic test_lat1();
        do_reset();
        ifc1.cpu_req = 1; ifc1.cpu_we = 0; ifc1.cpu_addr = 32'h08;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if ({ifc1.mem_en, ifc1.cpu_ack, ifc1.cpu_stall} !== {k % 3 == 1, k % 3 == 2, k % 3 != 2}) begin
                errors++;
                $display("FAIL lat1_c%0d en/ack/stall got %b%b%b exp %b%b%b", k,
                         ifc1.mem_en, ifc1.cpu_ack, ifc1.cpu_stall, k % 3 == 1, k % 3 == 2, k % 3 != 2);
            end
        end
        checks++;
        if (ifc1.cpu_rdata !== 32'h5A5A_0008) begin
            errors++;
            $display("FAIL lat1_data got %h exp 5a5a0008", ifc1.cpu_rdata);
        end
        ifc1.cpu_req = 0;
        step();
    endtask

    // Reference: each grant at cycle d owns memory for d+1..d+LAT and acks at d+LAT+1;
    // a new grant may be issued in the ack cycle (other port only) or any later cycle.
    task automatic test_random();
        int          busy_end;
        int          cur_d;
        logic        cur_owner;
        logic        cur_we;
        logic [31:0] cur_addr;
        logic        last_m;
        logic        pend    [2];
        logic        we_p    [2];
        logic [31:0] addr_p  [2];
        logic [31:0] wdata_p [2];
        int          ack_at  [2];
        logic [31:0] exp_rd  [2];
        logic [31:0] got_rd;
        logic [4:0]  exp_v;
        logic [4:0]  got_v;
        logic        g;
        do_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = mem[i];
        busy_end = -1; cur_d = -100; cur_owner = 0; cur_we = 0; cur_addr = 0; last_m = 1;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; we_p[p] = 0; addr_p[p] = 0; wdata_p[p] = 0; ack_at[p] = -1; exp_rd[p] = 0;
        end
        for (int t = 0; t < 400; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]    = 1;
                    we_p[p]    = 1'($urandom_range(0, 1));
                    addr_p[p]  = 32'($urandom_range(0, 255));
                    wdata_p[p] = $urandom;
                end
            end
            ifc.cpu_req = pend[0]; ifc.cpu_we = we_p[0]; ifc.cpu_addr = addr_p[0]; ifc.cpu_wdata = wdata_p[0];
            ifc.ld_req  = pend[1]; ifc.ld_we  = we_p[1]; ifc.ld_addr  = addr_p[1]; ifc.ld_wdata  = wdata_p[1];
            #1;
            exp_v = {(t > cur_d) && (t <= busy_end), (t > cur_d) && (t < busy_end),
                     ack_at[0] == t, ack_at[1] == t, pend[0] && (ack_at[0] != t)};
            got_v = {ifc.busy, ifc.mem_en, ifc.cpu_ack, ifc.ld_ack, ifc.cpu_stall};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL rand_t%0d busy/en/cack/lack/stall got %b exp %b", t, got_v, exp_v);
            end
            if ((t > cur_d) && (t < busy_end)) begin
                checks++;
                if (ifc.owner !== cur_owner || ifc.mem_addr !== cur_addr || ifc.mem_we !== cur_we) begin
                    errors++;
                    $display("FAIL rand_t%0d own/addr/we got %b/%h/%b exp %b/%h/%b", t,
                             ifc.owner, ifc.mem_addr, ifc.mem_we, cur_owner, cur_addr, cur_we);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (ack_at[p] == t) begin
                    got_rd = (p == 0) ? ifc.cpu_rdata : ifc.ld_rdata;
                    checks++;
                    if (got_rd !== exp_rd[p]) begin
                        errors++;
                        $display("FAIL rand_t%0d rdata port%0d got %h exp %h", t, p, got_rd, exp_rd[p]);
                    end
                    pend[p] = 0;
                    last_m  = 1'(p);
                end
            end
            if (t >= busy_end && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) g = ~last_m;
                else                    g = pend[1];
                cur_d = t; busy_end = t + LATV + 1; cur_owner = g;
                cur_we = we_p[g]; cur_addr = addr_p[g];
                ack_at[g] = busy_end;
                if (we_p[g]) model_mem[addr_p[g][7:0]] = wdata_p[g];
                else         exp_rd[g] = model_mem[addr_p[g][7:0]];
            end
            @(posedge clk);
            #1;
        end
        ifc.cpu_req = 0; ifc.ld_req = 0;
        repeat (LATV + 3) step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        clear_inputs();
        test_reset();
        test_cpu_read();
        test_ld_write();
        test_simultaneous();
        test_contention();
        test_reset_mid_acc();
        test_lat1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
